spi_slv16: RTL
==============

// Module: spi_slv16
// PURPOSE
//  SPI responder (slave) for 16-bit frames; the other end of SPI_mstr16.
//  SCLK idles high. The master drives MOSI on SCLK fall and samples MISO on SCLK rise.
//  All pins are oversampled in the clk domain. On each frame it returns tx_data
//  on MISO, captures the received command, and pulses cmd_rdy.
// PARAMETERS
//  WIDTH        16  frame length in bits (>=2)
//  SYNC_STAGES  2   synchronizer flops on SS_n/SCLK/MOSI (>=2)
// PORTS
//  clk      in   1      system clock; all logic on posedge
//  rst      in   1      synchronous, active-high reset
//  SS_n     in   1      slave select, active low, async to clk
//  SCLK     in   1      serial clock from master, async to clk
//  MOSI     in   1      serial data from master
//  MISO     out  1      serial data to master; 1'bz while SS_n pin high
//  wrt      in   1      load tx_data into tx buffer this cycle
//  tx_data  in   WIDTH  response word for next frame
//  cmd      out  WIDTH  last complete received frame
//  cmd_rdy  out  1      1-clk pulse when cmd updates
//  busy     out  1      high while a frame is in progress (state ACTIVE)
//  frm_err  out  1      1-clk pulse on short/long frame (only with SPI_FRM_ERR_EN)
// BEHAVIOUR
//  Reset values
//   - state IDLE; cmd=0, cmd_rdy=0, busy=0, frm_err=0; tx_buf=0, shft=0, bit_cnt=0.
//   - Sync chains: SCLK->1, MOSI->0, SS_n->0 (deliberate: no false SS_n fall after reset).
//  Edge detect
//   - ss_fall/ss_rise/sclk_rise come from the last sync stage vs one extra flop.
//  tx buffer
//   - wrt=1 -> tx_buf<=tx_data on the next edge, in any state.
//   - A write during ACTIVE affects the next frame only.
//  IDLE
//   - ss_fall -> ACTIVE; shft<=tx_buf; bit_cnt<=0.
//   - ss_rise and SCLK edges are ignored.
//  ACTIVE
//   - sclk_rise with bit_cnt<WIDTH -> shft<={shft[WIDTH-2:0],MOSI_sync}; bit_cnt++.
//   - sclk_rise with bit_cnt==WIDTH -> ignored (saturates, no shift).
//   - ss_rise -> IDLE.
//     - bit_cnt==WIDTH: cmd<=shft and cmd_rdy=1 for exactly 1 clk.
//     - otherwise: cmd held, no cmd_rdy.
//  MISO
//   - MISO = SS_n(pin) ? 1'bz : shft[WIDTH-1] (combinational).
//   - Next bit appears SYNC_STAGES+1 clk after the SCLK rise at the pin.
//  Latency
//   - cmd_rdy asserts SYNC_STAGES+2 clk after SS_n rises at the pin.
//  Master timing requirement (SPI_mstr16 meets both)
//   - SCLK half-period >= SYNC_STAGES+3 clk.
//   - SS_n fall to first SCLK fall >= SYNC_STAGES+2 clk.
//  Simultaneous events
//   - wrt in the same cycle as ss_fall: the shift register loads the old tx_buf.
//   - ss_rise and sclk_rise in the same cycle: the shift is applied first, then the count is checked.
//  Reset mid-frame
//   - Abort to IDLE; nothing captured.
//   - If SS_n stays low, no frame starts until SS_n goes high then low again.
// CONFIGURATION
//  SPI_FRM_ERR_EN defined
//   - ss_rise in ACTIVE with bit_cnt!=WIDTH, or any sclk_rise seen with bit_cnt==WIDTH,
//     -> frm_err pulses 1 clk at the ss_rise and cmd is not updated.
//  SPI_FRM_ERR_EN undefined
//   - frm_err is tied 0; bad frames are silently discarded.
// TESTING
//  1 rst; wrt tx_data=16'hA5C3; master sends 16'h0000
//    -> cmd=16'h0000, one cmd_rdy pulse, master rd_data=16'hA5C3.
//  2 tx_data=16'h1234; master sends 16'hABCD
//    -> cmd=16'hABCD, rd_data=16'h1234, busy low after frame.
//  3 Frames 16'hFFFF then 16'h0001 back-to-back; wrt 16'h5555 mid-frame 1
//    -> frame1 rd_data=old tx_buf, frame2 rd_data=16'h5555, cmds captured in order.
//  4 8 SCLK cycles then SS_n high
//    -> no cmd_rdy, cmd unchanged.
//    -> frm_err pulses once iff SPI_FRM_ERR_EN; next full frame captures correctly.
//  5 rst pulse after 5 bits with SS_n held low
//    -> no cmd_rdy for that frame; next frame 16'h0F0F gives cmd=16'h0F0F.
//  6 SS_n high (idle and after each frame)
//    -> MISO==1'bz; MISO driven within 0 clk of SS_n falling at the pin.

Source files
------------

// File: rtl/spi_slv16.sv
// SPI responder for WIDTH-bit frames: SCLK idles high, data shifts on SCLK rise.
// Every pin is oversampled in the clk domain through SYNC_STAGES flops.
// Optional feature macro: SPI_FRM_ERR_EN adds a frame error pulse for short or long frames.
module spi_slv16 #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             SS_n,
   input  logic             SCLK,
   input  logic             MOSI,
   output logic             MISO,
   input  logic             wrt,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] cmd,
   output logic             cmd_rdy,
   output logic             busy,
   output logic             frm_err
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   // DONE is the cycle after ss_rise, so a shift taken with that rise is in the count first
   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                 state, nxt_state;
   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic                   ss_d, sclk_d;
   logic                   ss_fall, ss_rise, sclk_rise, mosi_s;
   logic [WIDTH-1:0]       tx_buf, shft;
   logic [CW-1:0]          bit_cnt;
   logic                   ld_shft, do_shift, fin, good_c;
`ifdef SPI_FRM_ERR_EN
   logic                   ovf, set_ovf, bad_c;
`endif

   // Synchronizers plus one edge-detect flop; SS_n resets low so reset never fakes a fall
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync   <= '0;
         sclk_sync <= '1;
         mosi_sync <= '0;
         ss_d      <= 1'b0;
         sclk_d    <= 1'b1;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         ss_d      <= ss_sync[SYNC_STAGES-1];
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
      end
   end

   assign ss_fall   = ss_d & ~ss_sync[SYNC_STAGES-1];
   assign ss_rise   = ~ss_d & ss_sync[SYNC_STAGES-1];
   assign sclk_rise = ~sclk_d & sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   // Next state and datapath strobes
   always_comb begin
      nxt_state = state;
      ld_shft   = 1'b0;
      do_shift  = 1'b0;
      fin       = 1'b0;
`ifdef SPI_FRM_ERR_EN
      set_ovf   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (ss_fall) begin
               nxt_state = ACTIVE;
               ld_shft   = 1'b1;
            end
         end
         ACTIVE: begin
            if (sclk_rise) begin
               if (bit_cnt < CW'(WIDTH)) do_shift = 1'b1;
`ifdef SPI_FRM_ERR_EN
               else                      set_ovf  = 1'b1;
`endif
            end
            if (ss_rise) nxt_state = DONE;
         end
         DONE: begin
            fin = 1'b1;
            if (ss_fall) begin
               nxt_state = ACTIVE;
               ld_shft   = 1'b1;
            end else begin
               nxt_state = IDLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

`ifdef SPI_FRM_ERR_EN
   assign good_c = fin & (bit_cnt == CW'(WIDTH)) & ~ovf;
   assign bad_c  = fin & ~good_c;
`else
   assign good_c = fin & (bit_cnt == CW'(WIDTH));
`endif

   // Tx buffer, shift register, bit counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_buf  <= '0;
         shft    <= '0;
         bit_cnt <= '0;
         cmd     <= '0;
         cmd_rdy <= 1'b0;
         busy    <= 1'b0;
      end else begin
         if (wrt) tx_buf <= tx_data;
         if (ld_shft) begin
            shft    <= tx_buf;
            bit_cnt <= '0;
         end else if (do_shift) begin
            shft    <= {shft[WIDTH-2:0], mosi_s};
            bit_cnt <= bit_cnt + CW'(1);
         end
         if (good_c) cmd <= shft;
         cmd_rdy <= good_c;
         busy    <= (nxt_state == ACTIVE);
      end
   end

`ifdef SPI_FRM_ERR_EN
   // Overflow flag and frame error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf     <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         if (ld_shft)      ovf <= 1'b0;
         else if (set_ovf) ovf <= 1'b1;
         frm_err <= bad_c;
      end
   end
`else
   assign frm_err = 1'b0;
`endif

   assign MISO = SS_n ? 1'bz : shft[WIDTH-1];

endmodule
